// File: rtl/sign_extender_if.sv
// -----------------------------------------------------------------------------
// sign_extender_if
// Bundles the immediate-widening unit's data/control signals.
//   i_in          immediate field to extend (IN_W bits)
//   i_zero_ext    0 = sign-extend, 1 = zero-extend
//   i_shamt       left-shift amount 0..3, applied after extension
//   i_in_valid    qualifies i_in / i_zero_ext / i_shamt for capture
//   o_extended    combinational extended (and shifted) result
//   o_extended_q  registered copy of o_extended
//   o_out_valid   high the cycle after a captured i_in_valid
//   o_neg_q       registered sign flag of the captured input
// Modports: master drives the inputs (datapath/bench), slave is the extender.
// -----------------------------------------------------------------------------
interface sign_extender_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  i_in;
    logic             i_zero_ext;
    logic [1:0]       i_shamt;
    logic             i_in_valid;
    logic [OUT_W-1:0] o_extended;
    logic [OUT_W-1:0] o_extended_q;
    logic             o_out_valid;
    logic             o_neg_q;

    modport master (
        output i_in, i_zero_ext, i_shamt, i_in_valid,
        input  o_extended, o_extended_q, o_out_valid, o_neg_q
    );

    modport slave (
        input  i_in, i_zero_ext, i_shamt, i_in_valid,
        output o_extended, o_extended_q, o_out_valid, o_neg_q
    );
endinterface

// File: rtl/sign_extender.sv
// -----------------------------------------------------------------------------
// sign_extender
// Widens an IN_W-bit instruction immediate to an OUT_W-bit operand by sign- or
// zero-extension, followed by an optional left shift of 0..3 bits. The result
// is available combinationally and as a one-cycle registered, valid-tagged copy.
// Ports:
//   clk    system clock, rising-edge
//   rst_n  asynchronous active-low reset (clears the register stage only)
//   bus    sign_extender_if.slave (see interface file for the signal list)
// -----------------------------------------------------------------------------
module sign_extender #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    sign_extender_if.slave  bus
);
    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_extended;
    logic             w_neg;

    logic [OUT_W-1:0] r_extended_q;
    logic             r_neg_q;
    logic             r_out_valid;

    // Fill bit is the input MSB for sign-extension, zero otherwise.
    assign w_neg      = ~bus.i_zero_ext & bus.i_in[IN_W-1];
    assign w_ext      = {{EXT_W{w_neg}}, bus.i_in};
    // Bits pushed past the MSB are dropped; no overflow indication.
    assign w_extended = w_ext << bus.i_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_extended_q <= '0;
            r_neg_q      <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= bus.i_in_valid;
            if (bus.i_in_valid) begin
                r_extended_q <= w_extended;
                r_neg_q      <= w_neg;
            end
        end
    end

    assign bus.o_extended   = w_extended;
    assign bus.o_extended_q = r_extended_q;
    assign bus.o_out_valid  = r_out_valid;
    assign bus.o_neg_q      = r_neg_q;
endmodule

// File: tb/tb_sign_extender.sv
module tb_sign_extender;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    typedef struct packed {
        logic [OUT_W-1:0] ext;
        logic             neg;
    } exp_t;

    typedef struct packed {
        logic            valid;
        logic [IN_W-1:0] din;
        logic            ze;
        logic [1:0]      sh;
    } stim_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    exp_t  sb[$];
    stim_t stim_q[$];
    logic [OUT_W-1:0] hold_ext = '0;
    logic             hold_neg = 1'b0;

    sign_extender_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sign_extender #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed cast for sign-extension, then shift.
    function automatic logic [OUT_W-1:0] model_ext(logic [IN_W-1:0] v, logic ze, logic [1:0] sh);
        logic [OUT_W-1:0] w;
        if (ze) w = {{(OUT_W-IN_W){1'b0}}, v};
        else    w = OUT_W'($signed(v));
        return w << sh;
    endfunction

    task automatic drive(input logic valid, input logic [IN_W-1:0] din,
                         input logic ze, input logic [1:0] sh);
        bus.i_in_valid = valid;
        bus.i_in       = din;
        bus.i_zero_ext = ze;
        bus.i_shamt    = sh;
    endtask

    task automatic check_comb(input string name, input logic [IN_W-1:0] din,
                              input logic ze, input logic [1:0] sh,
                              input logic [OUT_W-1:0] exp);
        drive(1'b0, din, ze, sh);
        #1;
        checks++;
        if (bus.o_extended !== exp) begin
            errors++;
            $display("FAIL %s: extended=%h expected=%h", name, bus.o_extended, exp);
        end
    endtask

    // Runs stim_q one entry per cycle; at each negedge, outputs from the
    // previous capture are compared against the scoreboard before new drive.
    task automatic run_stream(input string name);
        logic prev_valid;
        exp_t e;
        int   n;
        prev_valid = 1'b0;
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_out_valid !== prev_valid) begin
                errors++;
                $display("FAIL %s[%0d] out_valid: got=%b expected=%b", name, i, bus.o_out_valid, prev_valid);
            end
            if (prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s[%0d] scoreboard: empty queue", name, i);
                end else begin
                    e = sb.pop_front();
                    hold_ext = e.ext;
                    hold_neg = e.neg;
                end
            end
            checks++;
            if (bus.o_extended_q !== hold_ext) begin
                errors++;
                $display("FAIL %s[%0d] extended_q: got=%h expected=%h", name, i, bus.o_extended_q, hold_ext);
            end
            checks++;
            if (bus.o_neg_q !== hold_neg) begin
                errors++;
                $display("FAIL %s[%0d] neg_q: got=%b expected=%b", name, i, bus.o_neg_q, hold_neg);
            end
            if (i < n) begin
                stim_t s;
                s = stim_q.pop_front();
                drive(s.valid, s.din, s.ze, s.sh);
                prev_valid = s.valid;
            end else begin
                drive(1'b0, '0, 1'b0, 2'd0);
                prev_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'hDF, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_extended_q !== 16'h0000 || bus.o_neg_q !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: q=%h neg=%b vld=%b expected 0000/0/0",
                     bus.o_extended_q, bus.o_neg_q, bus.o_out_valid);
        end
        checks++;
        if (bus.o_extended !== 16'hFFDF) begin
            errors++;
            $display("FAIL reset_comb: extended=%h expected=ffdf", bus.o_extended);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 2'd0);
        rst_n = 1'b1;
        hold_ext = '0;
        hold_neg = 1'b0;
    endtask

    task automatic test_sign_ext();
        check_comb("sext_0",   8'd0,   1'b0, 2'd0, 16'h0000);
        check_comb("sext_97",  8'd97,  1'b0, 2'd0, 16'h0061);
        check_comb("sext_128", 8'd128, 1'b0, 2'd0, 16'hFF80);
        check_comb("sext_223", 8'd223, 1'b0, 2'd0, 16'hFFDF);
        check_comb("sext_7f",  8'h7F,  1'b0, 2'd0, 16'h007F);
        check_comb("sext_ff",  8'hFF,  1'b0, 2'd0, 16'hFFFF);
    endtask

    task automatic test_zero_ext();
        check_comb("zext_223", 8'd223, 1'b1, 2'd0, 16'h00DF);
        check_comb("zext_128", 8'd128, 1'b1, 2'd0, 16'h0080);
        check_comb("zext_7f",  8'h7F,  1'b1, 2'd0, 16'h007F);
        check_comb("zext_ff",  8'hFF,  1'b1, 2'd0, 16'h00FF);
    endtask

    task automatic test_shift();
        check_comb("shift_ff_1",  8'hFF, 1'b0, 2'd1, 16'hFFFE);
        check_comb("shift_40_3",  8'h40, 1'b0, 2'd3, 16'h0200);
        check_comb("shift_z80_3", 8'h80, 1'b1, 2'd3, 16'h0400);
        check_comb("shift_81_2",  8'h81, 1'b0, 2'd2, 16'hFE04);
    endtask

    task automatic test_register();
        stim_q.push_back('{1'b1, 8'h80, 1'b0, 2'd0});
        sb.push_back('{16'hFF80, 1'b1});
        stim_q.push_back('{1'b0, 8'h11, 1'b0, 2'd0});
        run_stream("register");
    endtask

    task automatic test_back_to_back();
        stim_q.push_back('{1'b1, 8'h01, 1'b0, 2'd0});
        sb.push_back('{16'h0001, 1'b0});
        stim_q.push_back('{1'b1, 8'h02, 1'b0, 2'd0});
        sb.push_back('{16'h0002, 1'b0});
        stim_q.push_back('{1'b1, 8'hFE, 1'b0, 2'd0});
        sb.push_back('{16'hFFFE, 1'b1});
        run_stream("back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            stim_t s;
            s.valid = 1'($urandom_range(0, 1));
            s.din   = 8'($urandom);
            s.ze    = 1'($urandom_range(0, 1));
            s.sh    = 2'($urandom_range(0, 3));
            stim_q.push_back(s);
            if (s.valid)
                sb.push_back('{model_ext(s.din, s.ze, s.sh), (~s.ze & s.din[IN_W-1])});
        end
        run_stream("random");
    endtask

    task automatic test_reset_mid();
        stim_q.push_back('{1'b1, 8'hDF, 1'b0, 2'd0});
        sb.push_back('{16'hFFDF, 1'b1});
        run_stream("pre_reset");
        // Pending capture is set up, then reset lands between edges.
        @(negedge clk);
        drive(1'b1, 8'hDF, 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_extended_q !== 16'h0000 || bus.o_neg_q !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: q=%h neg=%b vld=%b expected 0000/0/0",
                     bus.o_extended_q, bus.o_neg_q, bus.o_out_valid);
        end
        checks++;
        if (bus.o_extended !== 16'hFFDF) begin
            errors++;
            $display("FAIL mid_reset_comb: extended=%h expected=ffdf", bus.o_extended);
        end
        @(negedge clk);
        checks++;
        if (bus.o_extended_q !== 16'h0000 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: q=%h vld=%b expected 0000/0", bus.o_extended_q, bus.o_out_valid);
        end
        drive(1'b0, '0, 1'b0, 2'd0);
        rst_n = 1'b1;
        sb.delete();
        hold_ext = '0;
        hold_neg = 1'b0;
        stim_q.push_back('{1'b1, 8'h05, 1'b1, 2'd1});
        sb.push_back('{16'h000A, 1'b0});
        run_stream("post_reset");
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_zero_ext();
        test_shift();
        test_register();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sign_extender.md
Name:
sign_extender

Overview:
- Immediate-widening unit for the stack processor datapath.
- Takes an IN_W-bit immediate field from the instruction and produces an OUT_W-bit operand.
- Default operation is sign-extension: 8-bit in, 16-bit out.
- Provides an immediate combinational result for same-cycle datapath use and a registered, valid-tagged copy for pipelined consumers.
- Zero-extension and small left-shift options cover unsigned immediates and word-aligned offsets.

Parameters:
- IN_W, 8, width of the immediate input; legal range 2 ≤ IN_W < OUT_W.
- OUT_W, 16, width of the extended result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  IN_W  immediate field to extend.
- zero_ext  input  1  0 = sign-extend; 1 = zero-extend.
- shamt  input  2  left-shift amount, 0..3, applied after extension.
- in_valid  input  1  qualifies `in`, `zero_ext` and `shamt` for capture into the register stage.
- extended  output  OUT_W  combinational extended (and shifted) result.
- extended_q  output  OUT_W  registered copy of `extended`.
- out_valid  output  1  high the cycle after a captured `in_valid`.
- neg_q  output  1  registered sign flag of the captured input: `in[IN_W-1]` when `zero_ext`=0, else 0.

Behaviour:
- Combinational path, no clock involvement:
  - ext = {(OUT_W-IN_W) copies of in[IN_W-1], in} when zero_ext=0.
  - ext = {(OUT_W-IN_W) zeros, in} when zero_ext=1.
  - extended = (ext << shamt), truncated to OUT_W bits; zeros fill the low bits; bits shifted past the MSB are discarded, with no overflow flag.
- `extended` responds to any input change with zero latency, independent of clk, rst_n and in_valid.
- Lower IN_W bits of the unshifted result always equal `in` exactly.
- Upper bits are all-ones iff zero_ext=0 and in[IN_W-1]=1; otherwise all-zeros.
- Register stage:
  - On rising clk with in_valid=1: extended_q ← extended, neg_q ← computed sign flag, out_valid ← 1.
  - On rising clk with in_valid=0: extended_q and neg_q hold; out_valid ← 0.
  - Latency is one cycle; back-to-back valid inputs give back-to-back valid outputs at full throughput.
  - No backpressure; the consumer must take the data in the out_valid cycle.
- Reset:
  - rst_n low immediately forces extended_q=0, neg_q=0, out_valid=0, regardless of clk.
  - Reset asserted mid-operation discards any pending capture.
  - While rst_n is low, `extended` still tracks its inputs combinationally.
  - The first capture after release occurs on the first rising edge with rst_n high and in_valid=1.
- Boundaries:
  - in=0 → 0.
  - Most-positive input (0x7F at default width) → 0x007F.
  - Most-negative input (0x80) → 0xFF80.
  - All-ones input (0xFF) → 0xFFFF when sign-extended, 0x00FF when zero-extended.
- X/Z on `in` propagates; no sanitising is performed.

Test Plan:
- zero_ext=0, shamt=0: in=0 → extended=0x0000; in=97 → 0x0061; in=128 → 0xFF80; in=223 → 0xFFDF. Check each after settling, no clock required.
- zero_ext=1, shamt=0: in=223 → 0x00DF; in=128 → 0x0080; in=0x7F → 0x007F.
- Shift: zero_ext=0, in=0xFF, shamt=1 → 0xFFFE. in=0x40, shamt=3 → 0x0200. zero_ext=1, in=0x80, shamt=3 → 0x0400.
- Register timing: drive in_valid=1 with in=0x80 for one cycle, then in_valid=0 → next cycle extended_q=0xFF80, neg_q=1, out_valid=1. The following cycle out_valid=0 and extended_q holds 0xFF80.
- Streaming: in_valid=1 for 3 cycles with in=1,2,0xFE → out_valid high for 3 consecutive cycles with extended_q=0x0001, 0x0002, 0xFFFE.
- Reset: capture in=0xDF, then pull rst_n low between clock edges → extended_q=0, neg_q=0, out_valid=0 immediately, while `extended` still reads 0xFFDF.
